// File: rtl/sound_frame_seq_pkg.sv
// Shared constants and types for the APU frame sequencer and its length counters.
package sound_frame_seq_pkg;

  localparam int unsigned FS_STEPS     = 8;
  localparam int unsigned LEN_MAX_SQ   = 64;
  localparam int unsigned LEN_MAX_WAVE = 256;

  localparam logic [FS_STEPS-1:0] LEN_STEP_MASK = 8'b0101_0101;
  localparam logic [FS_STEPS-1:0] SWP_STEP_MASK = 8'b0100_0100;
  localparam logic [FS_STEPS-1:0] ENV_STEP_MASK = 8'b1000_0000;

  localparam int unsigned CH_SQ1   = 0;
  localparam int unsigned CH_SQ2   = 1;
  localparam int unsigned CH_WAVE  = 2;
  localparam int unsigned CH_NOISE = 3;

  typedef logic [$clog2(FS_STEPS)-1:0] fs_step_t;
  typedef logic [8:0]                  len_cnt_t;

  function automatic int unsigned len_max(int unsigned ch);
    return (ch == CH_WAVE) ? LEN_MAX_WAVE : LEN_MAX_SQ;
  endfunction

endpackage

// File: rtl/sound_frame_seq_if.sv
// Register-side control and status bundle between the APU register file and the frame sequencer.
interface sound_frame_seq_if;
  import sound_frame_seq_pkg::*;

  logic       apu_on;
  logic       div_bit;
  logic [3:0] trigger;
  logic [3:0] len_load;
  logic [7:0] len_data;
  logic [3:0] len_enable;
  logic [3:0] dac_off;
  logic       len_tick;
  logic       sweep_tick;
  logic       env_tick;
  fs_step_t   step;
  logic [3:0] ch_active;

  modport master (
    output apu_on, div_bit, trigger, len_load, len_data, len_enable, dac_off,
    input  len_tick, sweep_tick, env_tick, step, ch_active
  );

  modport slave (
    input  apu_on, div_bit, trigger, len_load, len_data, len_enable, dac_off,
    output len_tick, sweep_tick, env_tick, step, ch_active
  );

endinterface

// File: rtl/sound_frame_seq_len_ctr.sv
// One channel length counter plus its running flag (load > trigger > tick priority).
module sound_len_ctr
  import sound_frame_seq_pkg::*;
#(
  parameter int unsigned MAX = LEN_MAX_SQ
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       apu_on_i,
  input  logic       trigger_i,
  input  logic       len_load_i,
  input  logic [7:0] len_data_i,
  input  logic       len_enable_i,
  input  logic       dac_off_i,
  input  logic       len_tick_i,
  output logic       active_o
);

  len_cnt_t cnt_q, cnt_d;
  logic     active_q, active_d;
  len_cnt_t load_val;

  // MAX-1 doubles as the data mask: 6 bits for 64-length channels, 8 bits for wave
  assign load_val = len_cnt_t'(MAX) - ({1'b0, len_data_i} & len_cnt_t'(MAX - 1));

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (len_load_i) begin
      cnt_d = load_val;
    end else if (trigger_i && apu_on_i) begin
      if (cnt_q == '0) cnt_d = len_cnt_t'(MAX);
      active_d = 1'b1;
    end else if (apu_on_i && len_tick_i && len_enable_i && cnt_q != '0) begin
      cnt_d = cnt_q - len_cnt_t'(1);
      if (cnt_q == len_cnt_t'(1)) active_d = 1'b0;
    end
    if (!apu_on_i || dac_off_i) active_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/sound_frame_seq.sv
// APU frame sequencer: 512 Hz step strobe, 8-step tick schedule and four length counters.
// Define SOUND_FS_DIV_SYNC_EN to step on falling edges of div_bit instead of the prescaler.
module sound_frame_seq
  import sound_frame_seq_pkg::*;
#(
  parameter int unsigned PRESCALE = 8192,
  parameter int unsigned PS_WIDTH = 13
) (
  input logic              clk,
  input logic              rst,
  sound_frame_seq_if.slave bus
);

  logic       step_en;
  fs_step_t   step_q, step_d;
  logic       len_tick_q, len_tick_d;
  logic       sweep_tick_q, sweep_tick_d;
  logic       env_tick_q, env_tick_d;
  logic [3:0] ch_active_w;

`ifdef SOUND_FS_DIV_SYNC_EN
  logic div_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_q <= 1'b0;
    else     div_q <= bus.div_bit;
  end

  assign step_en = bus.apu_on && div_q && !bus.div_bit;
`else
  logic [PS_WIDTH-1:0] ps_q, ps_d;
  logic                unused_div;

  assign unused_div = bus.div_bit;
  assign step_en    = bus.apu_on && (ps_q == PS_WIDTH'(PRESCALE - 1));

  always_comb begin
    if (!bus.apu_on || step_en) ps_d = '0;
    else                        ps_d = ps_q + PS_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ps_q <= '0;
    else     ps_q <= ps_d;
  end
`endif

  // Ticks decode the step value before it advances, so they lag step_en by one cycle
  always_comb begin
    step_d       = step_q;
    len_tick_d   = 1'b0;
    sweep_tick_d = 1'b0;
    env_tick_d   = 1'b0;
    if (!bus.apu_on) begin
      step_d = '0;
    end else if (step_en) begin
      step_d       = step_q + fs_step_t'(1);
      len_tick_d   = LEN_STEP_MASK[step_q];
      sweep_tick_d = SWP_STEP_MASK[step_q];
      env_tick_d   = ENV_STEP_MASK[step_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q       <= '0;
      len_tick_q   <= 1'b0;
      sweep_tick_q <= 1'b0;
      env_tick_q   <= 1'b0;
    end else begin
      step_q       <= step_d;
      len_tick_q   <= len_tick_d;
      sweep_tick_q <= sweep_tick_d;
      env_tick_q   <= env_tick_d;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_ch
    sound_len_ctr #(.MAX(len_max(g))) u_len (
      .clk          (clk),
      .rst          (rst),
      .apu_on_i     (bus.apu_on),
      .trigger_i    (bus.trigger[g]),
      .len_load_i   (bus.len_load[g]),
      .len_data_i   (bus.len_data),
      .len_enable_i (bus.len_enable[g]),
      .dac_off_i    (bus.dac_off[g]),
      .len_tick_i   (len_tick_q),
      .active_o     (ch_active_w[g])
    );
  end

  assign bus.len_tick   = len_tick_q;
  assign bus.sweep_tick = sweep_tick_q;
  assign bus.env_tick   = env_tick_q;
  assign bus.step       = step_q;
  assign bus.ch_active  = ch_active_w;

endmodule
